// File: rtl/mips_mc_controller_if.sv
// ---------------------------------------------------------------------------
// mips_mc_controller_if
//   Bundle between the multicycle sequencing controller and the shared
//   datapath.
//   Datapath -> controller : op, funct, zero, mem_ready
//   Controller -> datapath : memory strobes (memen, memwrite, iord), IR load
//                            (irwrite), register file controls (regdst,
//                            memtoreg, regwrite), ALU operand and operation
//                            selects (alusrca, alusrcb, alucontrol), PC
//                            controls (pcsrc, pcen), and the sticky trap
//                            flag err.
//   Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       memen;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       err;

  modport master (
    input  op, funct, zero, mem_ready,
    output memen, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, err
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memen, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, err
  );
endinterface

// File: rtl/mips_mc_controller.sv
// ---------------------------------------------------------------------------
// mips_mc_controller
//   Moore sequencing controller for the multicycle MIPS datapath. Steps one
//   instruction at a time through fetch, decode, execute, memory and
//   writeback, and traps illegal encodings into a terminal ERROR state.
//
//   Ports:
//     clk  - core clock, all state changes on the rising edge
//     rst  - asynchronous active-low reset; also forces every output to 0
//     bus  - mips_mc_controller_if.master (decode inputs, handshake, strobes)
//
//   Parameter:
//     WAIT_LIMIT - wait cycles a memory state tolerates without mem_ready
//                  (1..255) before trapping.
//
//   Build option:
//     MC_MEM_WAIT_EN - when defined, memory states wait on mem_ready with an
//                      8-bit wait counter and timeout trap. When undefined,
//                      mem_ready is ignored and every memory state lasts one
//                      cycle; err is then raised only by illegal encodings.
// ---------------------------------------------------------------------------
module mips_mc_controller #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_mc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ERROR   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True for the R-type functions this core implements.
  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT: funct_legal = 1'b1;
      default:                          funct_legal = 1'b0;
    endcase
  endfunction

  // ALU operation for an R-type function; add is a harmless fallback since
  // illegal functions never reach EXECUTE.
  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      F_ADD:   alu_of_funct = ALU_ADD;
      F_SUB:   alu_of_funct = ALU_SUB;
      F_AND:   alu_of_funct = ALU_AND;
      F_OR:    alu_of_funct = ALU_OR;
      F_SLT:   alu_of_funct = ALU_SLT;
      default: alu_of_funct = ALU_ADD;
    endcase
  endfunction

  state_e state_q, state_d;
  logic   ready_s;    // effective memory-ready
  logic   timeout_s;  // memory state has exhausted its wait budget
  logic   mem_state_s;

  assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);

`ifdef MC_MEM_WAIT_EN
  localparam logic [7:0] WAIT_LIMIT_C = WAIT_LIMIT[7:0];

  logic [7:0] wait_q, wait_d;

  assign ready_s = bus.mem_ready;
  // The counter stops at the limit: a ready in that cycle still succeeds,
  // otherwise the state traps on the coming edge.
  assign timeout_s = mem_state_s && !bus.mem_ready && (wait_q == WAIT_LIMIT_C);

  // Wait counter: cleared whenever the state changes, counts idle memory cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (mem_state_s && !bus.mem_ready) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  localparam logic [7:0] unused_wait_limit_c = WAIT_LIMIT[7:0];
  logic unused_mem_ready_s;

  assign unused_mem_ready_s = bus.mem_ready;
  assign ready_s            = 1'b1;
  assign timeout_s          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (ready_s) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal(bus.funct) ? S_EXECUTE : S_ERROR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (ready_s) begin
          state_d = S_MEMWB;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (ready_s) begin
          state_d = S_FETCH;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMWB:   state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_ERROR;
    endcase
  end

  logic       memen_s, memwrite_s, iord_s, irwrite_s, regdst_s, memtoreg_s;
  logic       regwrite_s, alusrca_s, pcen_s, err_s;
  logic [1:0] alusrcb_s, pcsrc_s;
  logic [2:0] alucontrol_s;

  // Moore output decode; only FETCH and BRANCH gate on live inputs.
  always_comb begin
    memen_s      = 1'b0;
    memwrite_s   = 1'b0;
    iord_s       = 1'b0;
    irwrite_s    = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    pcsrc_s      = 2'b00;
    pcen_s       = 1'b0;
    alucontrol_s = 3'b000;
    err_s        = 1'b0;
    case (state_q)
      S_FETCH: begin
        memen_s      = 1'b1;
        alusrcb_s    = 2'b01;
        alucontrol_s = ALU_ADD;
        irwrite_s    = ready_s;
        pcen_s       = ready_s;
      end
      S_DECODE: begin
        alusrcb_s    = 2'b11;
        alucontrol_s = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = ALU_ADD;
      end
      S_MEMRD: begin
        memen_s = 1'b1;
        iord_s  = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
      end
      S_MEMWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_s    = 1'b1;
        alucontrol_s = alu_of_funct(bus.funct);
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = 2'b01;
        pcen_s       = bus.zero;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc_s = 2'b10;
        pcen_s  = 1'b1;
      end
      S_ERROR: err_s = 1'b1;
      default: err_s = 1'b1;
    endcase
  end

  // Reset holds every output low, including the FETCH strobes.
  assign bus.memen      = rst & memen_s;
  assign bus.memwrite   = rst & memwrite_s;
  assign bus.iord       = rst & iord_s;
  assign bus.irwrite    = rst & irwrite_s;
  assign bus.regdst     = rst & regdst_s;
  assign bus.memtoreg   = rst & memtoreg_s;
  assign bus.regwrite   = rst & regwrite_s;
  assign bus.alusrca    = rst & alusrca_s;
  assign bus.alusrcb    = {2{rst}} & alusrcb_s;
  assign bus.pcsrc      = {2{rst}} & pcsrc_s;
  assign bus.pcen       = rst & pcen_s;
  assign bus.alucontrol = {3{rst}} & alucontrol_s;
  assign bus.err        = rst & err_s;

endmodule

// File: tb/tb_mips_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_controller
//   Randomized instruction stream against a phase-list reference model.
//   Each instruction expands into the named phases it must visit; memory
//   phases repeat while mem_ready is low (when waits are built) and trap
//   after WL tolerated wait cycles. Every cycle the full output vector is
//   compared with the vector the phase name implies.
// ---------------------------------------------------------------------------
module tb_mips_mc_controller;
  localparam int WL = 3;
`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   rq[$];  // forced mem_ready pattern, consumed before random values

  mips_mc_controller_if bus();

  mips_mc_controller #(.WAIT_LIMIT(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // {memen,memwrite,iord,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrol,err}
  function automatic logic [31:0] obs();
    return {15'd0, bus.memen, bus.memwrite, bus.iord, bus.irwrite, bus.regdst,
            bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc,
            bus.pcen, bus.alucontrol, bus.err};
  endfunction

  function automatic logic [2:0] alu_for(input logic [5:0] f);
    if (f == 6'h22) return 3'b110;
    if (f == 6'h24) return 3'b000;
    if (f == 6'h25) return 3'b001;
    if (f == 6'h2a) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [31:0] exp_vec(input string ph, input bit rdy, input bit z,
                                          input logic [5:0] f);
    bit mn = 0, mw = 0, io = 0, ir = 0, rd = 0, mr = 0, rw = 0, sa = 0, pe = 0, er = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ac = 3'b000;
    if (ph == "fetch")        begin mn = 1; sb = 2'b01; ac = 3'b010; ir = rdy; pe = rdy; end
    else if (ph == "decode")  begin sb = 2'b11; ac = 3'b010; end
    else if (ph == "memadr" || ph == "addiex") begin sa = 1; sb = 2'b10; ac = 3'b010; end
    else if (ph == "memrd")   begin mn = 1; io = 1; end
    else if (ph == "memwb")   begin rw = 1; mr = 1; end
    else if (ph == "memwr")   begin mw = 1; io = 1; end
    else if (ph == "execute") begin sa = 1; ac = alu_for(f); end
    else if (ph == "aluwb")   begin rw = 1; rd = 1; end
    else if (ph == "branch")  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
    else if (ph == "addiwb")  begin rw = 1; end
    else if (ph == "jump")    begin ps = 2'b10; pe = 1; end
    else if (ph == "error")   begin er = 1; end
    return {15'd0, mn, mw, io, ir, rd, mr, rw, sa, sb, ps, pe, ac, er};
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] f);
    logic [5:0] ops[6]   = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2b};
    logic [5:0] fns[5]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    bit ok = 0;
    foreach (ops[i]) if (ops[i] == op) ok = 1;
    if (ok && op == 6'h00) begin
      ok = 0;
      foreach (fns[i]) if (fns[i] == f) ok = 1;
    end
    return ok;
  endfunction

  function automatic bit next_ready();
    if (rq.size() > 0) return rq.pop_front();
    return ($urandom_range(0, 9) < 6);
  endfunction

  // One clock: drive inputs at the falling edge, check, then advance.
  task automatic do_cycle(input string ph, input bit rdy, input bit z);
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
    check_val(ph, obs(), exp_vec(ph, WAIT_EN ? rdy : 1'b1, z, bus.funct));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check_val("reset", obs(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("reset_hold", obs(), 32'd0);
    rst = 1'b1;
  endtask

  task automatic trap_and_reset(input bit z);
    for (int c = 0; c < 3; c++) do_cycle("error", 1'($urandom_range(0, 1)), z);
    reset_dut();
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input bit z);
    string ph[$];
    bit    r;
    bit    timed_out;
    bus.op    = op;
    bus.funct = f;
    ph.push_back("fetch");
    ph.push_back("decode");
    if (!is_legal(op, f))   ph.push_back("error");
    else if (op == 6'h23)   begin ph.push_back("memadr"); ph.push_back("memrd"); ph.push_back("memwb"); end
    else if (op == 6'h2b)   begin ph.push_back("memadr"); ph.push_back("memwr"); end
    else if (op == 6'h00)   begin ph.push_back("execute"); ph.push_back("aluwb"); end
    else if (op == 6'h04)   ph.push_back("branch");
    else if (op == 6'h08)   begin ph.push_back("addiex"); ph.push_back("addiwb"); end
    else                    ph.push_back("jump");
    foreach (ph[i]) begin
      if (ph[i] == "error") begin
        trap_and_reset(z);
        return;
      end
      if (ph[i] == "fetch" || ph[i] == "memrd" || ph[i] == "memwr") begin
        timed_out = 1'b0;
        for (int cnt = 0; cnt <= WL; cnt++) begin
          r = next_ready();
          do_cycle(ph[i], r, z);
          if (!WAIT_EN || r) break;
          if (cnt == WL) timed_out = 1'b1;
        end
        if (timed_out) begin
          trap_and_reset(z);
          return;
        end
      end else begin
        do_cycle(ph[i], 1'($urandom_range(0, 1)), z);
      end
    end
  endtask

  initial begin
    logic [5:0] lf[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    int k;
    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    reset_dut();

    // Directed: lw, beq taken/not taken, slt, nor trap.
    rq = {1'b1, 1'b1}; run_instr(6'h23, 6'h00, 1'b0); rq.delete();
    rq = {1'b1};       run_instr(6'h04, 6'h00, 1'b1); rq.delete();
    rq = {1'b1};       run_instr(6'h04, 6'h00, 1'b0); rq.delete();
    rq = {1'b1};       run_instr(6'h00, 6'h2a, 1'b0); rq.delete();
    rq = {1'b1};       run_instr(6'h00, 6'h27, 1'b0); rq.delete();

    // Directed: reset in the middle of MEMRD, then FETCH with ready.
    bus.op = 6'h23; bus.funct = 6'h00;
    do_cycle("fetch", 1'b1, 1'b0);
    do_cycle("decode", 1'b1, 1'b0);
    do_cycle("memadr", 1'b1, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    check_val("memrd_pre_rst", obs(), exp_vec("memrd", 1'b0, 1'b0, 6'h00));
    reset_dut();
    rq = {1'b1}; run_instr(6'h08, 6'h00, 1'b0); rq.delete();

    // Directed wait-state cases: two waits in MEMWR, ready exactly at the
    // limit, and a FETCH that never sees ready.
    rq = {1'b1, 1'b0, 1'b0, 1'b1};       run_instr(6'h2b, 6'h00, 1'b0); rq.delete();
    rq = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; run_instr(6'h02, 6'h00, 1'b0); rq.delete();
    rq = {1'b0, 1'b0, 1'b0, 1'b0};       run_instr(6'h08, 6'h00, 1'b0); rq.delete();

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       run_instr(6'h23, 6'($urandom), 1'($urandom));
        1:       run_instr(6'h2b, 6'($urandom), 1'($urandom));
        2:       run_instr(6'h04, 6'($urandom), 1'($urandom));
        3:       run_instr(6'h08, 6'($urandom), 1'($urandom));
        4:       run_instr(6'h02, 6'($urandom), 1'($urandom));
        5, 6:    run_instr(6'h00, lf[$urandom_range(0, 4)], 1'($urandom));
        7:       run_instr(6'h00, 6'($urandom), 1'($urandom));
        default: run_instr(6'($urandom), 6'($urandom), 1'($urandom));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle sequencing controller for the MIPS core: a Moore state machine that steps one shared datapath (single memory port, one ALU, IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback, one instruction at a time. It sits beside the datapath in place of the single-cycle combinational controller. It also waits on a memory-ready handshake and traps illegal encodings.

## Interface
- WAIT_LIMIT, 15: maximum cycles a memory state waits for `mem_ready` before trapping; 1..255.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completed the current access this cycle.
- memen  out  1  memory read request.
- memwrite  out  1  memory write request.
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load IR.
- regdst  out  1  write register: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- regwrite  out  1  register file write enable.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC register enable.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- err  out  1  sticky trap flag.

## Operation
- Supported ops:
  - lw (0x23), sw (0x2b), beq (0x04), addi (0x08), j (0x02).
  - R-type (0x00) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2a slt.
- States:
  - FETCH: memen, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
    - irwrite and pcen are asserted only when `mem_ready`=1.
    - Advances to DECODE on `mem_ready`.
  - DECODE: alusrca=0, alusrcb=11, add, computing the branch target.
    - Branches by op to MEMADR (lw/sw), EXECUTE (R), BRANCH, ADDIEX or JUMP.
    - Unknown op, or R-type with unknown funct, goes to ERROR.
  - MEMADR: alusrca=1, alusrcb=10, add. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: memen, iord=1. Goes to MEMWB on `mem_ready`.
  - MEMWB: regwrite, regdst=0, memtoreg=1. Goes to FETCH.
  - MEMWR: memwrite, iord=1. Goes to FETCH on `mem_ready`.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct. Goes to ALUWB.
  - ALUWB: regwrite, regdst=1, memtoreg=0. Goes to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=`zero`. Goes to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, add. Goes to ADDIWB.
  - ADDIWB: regwrite, regdst=0, memtoreg=0. Goes to FETCH.
  - JUMP: pcsrc=10, pcen=1. Goes to FETCH.
  - ERROR: all strobes 0, err=1. Terminal; left only by reset.
- Unlisted outputs are 0 in every state.
- Wait counter (8 bits):
  - Cleared on entry to any memory state (FETCH, MEMRD, MEMWR).
  - Increments each cycle `mem_ready`=0 in that state.
  - Reaching WAIT_LIMIT without ready goes to ERROR on the next edge.
  - `mem_ready` arriving in the same cycle the count reaches WAIT_LIMIT counts as success.
- memen and memwrite are held constant for the whole wait. The request is never dropped mid-access.

## Timing
- Reset (rst=0):
  - State becomes FETCH, wait counter 0, err=0.
  - All outputs are forced to 0 while rst=0, including FETCH strobes.
  - Applies mid-instruction; any in-flight access is abandoned.
- First FETCH strobes appear in the cycle after rst deasserts.
- Latency with zero wait states (cycles from FETCH to the next FETCH):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- Each wait cycle adds exactly 1 to the latency.
- Outputs are combinational from the registered state and counter, plus `zero`/`mem_ready` gating. The state register is the only sequential element besides the wait counter.

## Configuration
- MC_MEM_WAIT_EN defined: `mem_ready` handshake, wait counter and timeout behave as above.
- MC_MEM_WAIT_EN undefined:
  - `mem_ready` is ignored and treated as 1.
  - The wait counter is not built; memory states last exactly 1 cycle.
  - err is set only by illegal encodings.

## Test plan
- Reset: rst=0 during MEMRD -> all outputs 0 immediately; after release, FETCH with memen=1, pcen=1 (mem_ready=1).
- lw, op=0x23, mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 with memtoreg=1 only in cycle 5.
- beq, op=0x04:
  - zero=1 -> pcen=1, pcsrc=01 in cycle 3.
  - zero=0 -> pcen=0 in cycle 3.
- R-type, funct=0x2a -> alucontrol=111 in EXECUTE, regdst=1 in ALUWB.
- funct=0x27 (nor) -> ERROR after DECODE; err=1 and held until reset.
- With MC_MEM_WAIT_EN and WAIT_LIMIT=3:
  - mem_ready low 2 cycles in MEMWR -> memwrite held 3 cycles, then FETCH.
  - mem_ready never high -> ERROR after 3 wait cycles.
